// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and constants for the CPU run monitor: FSM states, dump
// section encodings and the default halt instruction encoding.
package cpu_mon_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        DRAIN    = 3'd1,
        DUMP_REG = 3'd2,
        DUMP_MEM = 3'd3,
        DONE     = 3'd4
    } mon_state_t;

    localparam logic SEC_REG = 1'b0;
    localparam logic SEC_MEM = 1'b1;

    // Wide enough for any practical instruction width; the top slices it.
    localparam logic [63:0] DEF_HALT_WORD = '1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Valid/ready dump port of the run monitor; master = monitor, slave = consumer.
interface cpu_run_monitor_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              dump_valid_o;
    logic              dump_ready_i;
    logic [DATA_W-1:0] dump_data_o;
    logic              dump_is_mem_o;
    logic [IDX_W-1:0]  dump_idx_o;

    modport master (
        output dump_valid_o,
        output dump_data_o,
        output dump_is_mem_o,
        output dump_idx_o,
        input  dump_ready_i
    );

    modport slave (
        input  dump_valid_o,
        input  dump_data_o,
        input  dump_is_mem_o,
        input  dump_idx_o,
        output dump_ready_i
    );
endinterface

// File: rtl/cpu_run_monitor_dump_seq.sv
// mon_dump_seq: valid/ready index sequencer walking the register and memory
// sections. Optional running checksum when MON_CHECKSUM_EN is defined.
module mon_dump_seq
    import cpu_mon_pkg::*;
#(
    parameter int NREG   = 8,
    parameter int NMEM   = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              active,
    input  logic              sec,
    input  logic [DATA_W-1:0] reg_data_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [IDX_W-1:0]  idx,
    output logic              sec_last,
    output logic [DATA_W-1:0] checksum_o,
    cpu_run_monitor_if.master dump
);

    logic              accept;
    logic [IDX_W-1:0]  last_idx;
    logic [DATA_W-1:0] word;

    assign accept   = active & dump.dump_ready_i;
    assign last_idx = (sec == SEC_MEM) ? IDX_W'(NMEM - 1) : IDX_W'(NREG - 1);
    assign sec_last = accept & (idx == last_idx);
    assign word     = (sec == SEC_MEM) ? mem_data_i : reg_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_n) begin
            idx <= '0;
        end else if (accept) begin
            idx <= (idx == last_idx) ? '0 : idx + 1'b1;
        end
    end

    assign dump.dump_valid_o  = active;
    assign dump.dump_data_o   = word;
    assign dump.dump_is_mem_o = sec;
    assign dump.dump_idx_o    = idx;

`ifdef MON_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk_i) begin
        if (rst_n) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + word;
        end
    end

    assign checksum_o = sum_q;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: counts executed instructions, ends the run on the halt word
// or a cycle limit, then stalls the CPU and dumps regs/mem (MON_CHECKSUM_EN adds checksum).
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   RUN      | CPU executing; count instructions, watch halt/limit
//   DRAIN    | CPU still running for DRAIN_CYCLES; counter frozen
//   DUMP_REG | CPU stalled; stream register file over dump port
//   DUMP_MEM | CPU stalled; stream data memory over dump port
//   DONE     | dump complete; stalled until reset
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int                 INSTR_W      = 16,
    parameter logic [INSTR_W-1:0] HALT_WORD    = DEF_HALT_WORD[INSTR_W-1:0],
    parameter int                 MAX_CYCLES   = 200,
    parameter int                 DRAIN_CYCLES = 2,
    parameter int                 NREG         = 8,
    parameter int                 NMEM         = 32,
    parameter int                 DATA_W       = 32,
    parameter int                 CNT_W        = 16,
    localparam int                RAW          = $clog2(NREG),
    localparam int                MAW          = $clog2(NMEM),
    localparam int                IDX_W        = max_int(RAW, MAW)
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               instr_valid_i,
    output logic               cpu_stall_o,
    output logic [RAW-1:0]     reg_addr_o,
    input  logic [DATA_W-1:0]  reg_data_i,
    output logic [MAW-1:0]     mem_addr_o,
    input  logic [DATA_W-1:0]  mem_data_i,
    cpu_run_monitor_if.master  dump,
    output logic               halted_o,
    output logic               timeout_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic [DATA_W-1:0]  checksum_o
);

    localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DC_W-1:0] DRAIN_LOAD =
        (DRAIN_CYCLES > 0) ? DC_W'(DRAIN_CYCLES - 1) : '0;

    mon_state_t       state, state_nxt;
    logic [DC_W-1:0]  drain_cnt;
    logic [IDX_W-1:0] idx;
    logic             sec_last;
    logic             dump_active;
    logic             sec;
    logic             is_halt;
    logic             cnt_hit;
    logic             end_run;

    assign is_halt = instr_valid_i && (instr_i == HALT_WORD);
    // The instruction that brings the count to MAX_CYCLES ends the run.
    assign cnt_hit = instr_valid_i && !is_halt &&
                     (cycle_cnt_o == CNT_W'(MAX_CYCLES - 1));
    assign end_run = is_halt || cnt_hit;

    always_ff @(posedge clk_i) begin
        if (rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (end_run) begin
                    state_nxt = (DRAIN_CYCLES == 0) ? DUMP_REG : DRAIN;
                end
            end
            DRAIN:    if (drain_cnt == '0) state_nxt = DUMP_REG;
            DUMP_REG: if (sec_last)        state_nxt = DUMP_MEM;
            DUMP_MEM: if (sec_last)        state_nxt = DONE;
            DONE:     state_nxt = DONE;
            default:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        cpu_stall_o = 1'b0;
        dump_active = 1'b0;
        sec         = SEC_REG;
        done_o      = 1'b0;
        case (state)
            DUMP_REG: begin
                cpu_stall_o = 1'b1;
                dump_active = 1'b1;
            end
            DUMP_MEM: begin
                cpu_stall_o = 1'b1;
                dump_active = 1'b1;
                sec         = SEC_MEM;
            end
            DONE: begin
                cpu_stall_o = 1'b1;
                done_o      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_n) begin
            cycle_cnt_o <= '0;
            halted_o    <= 1'b0;
            timeout_o   <= 1'b0;
            drain_cnt   <= '0;
        end else begin
            if (state == RUN) begin
                if (instr_valid_i && !is_halt &&
                    (cycle_cnt_o < CNT_W'(MAX_CYCLES))) begin
                    cycle_cnt_o <= cycle_cnt_o + 1'b1;
                end
                if (is_halt) begin
                    halted_o <= 1'b1;
                end else if (cnt_hit) begin
                    timeout_o <= 1'b1;
                end
                if (end_run) begin
                    drain_cnt <= DRAIN_LOAD;
                end
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
        end
    end

    assign reg_addr_o = idx[RAW-1:0];
    assign mem_addr_o = idx[MAW-1:0];

    mon_dump_seq #(
        .NREG   (NREG),
        .NMEM   (NMEM),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_dump_seq (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .active     (dump_active),
        .sec        (sec),
        .reg_data_i (reg_data_i),
        .mem_data_i (mem_data_i),
        .idx        (idx),
        .sec_last   (sec_last),
        .checksum_o (checksum_o),
        .dump       (dump)
    );

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: directed runs (halt, timeout, halt on
// the last allowed instruction, mid-dump reset, checksum) with a dump monitor.
module tb_cpu_run_monitor;
    import cpu_mon_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        cpu_stall;
    logic [2:0]  reg_addr;
    logic [4:0]  mem_addr;
    logic [31:0] reg_data, mem_data;
    logic        halted, timeout, done;
    logic [15:0] cnt;
    logic [31:0] checksum;

    logic [31:0] regs [8];
    logic [31:0] mems [32];

    typedef struct {
        logic [31:0] d;
        logic        m;
        logic [4:0]  i;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    cpu_run_monitor_if #(.DATA_W(32), .IDX_W(5)) dif ();

    cpu_run_monitor dut (
        .clk_i         (clk),
        .rst_n         (rst),
        .instr_i       (instr),
        .instr_valid_i (instr_valid),
        .cpu_stall_o   (cpu_stall),
        .reg_addr_o    (reg_addr),
        .reg_data_i    (reg_data),
        .mem_addr_o    (mem_addr),
        .mem_data_i    (mem_data),
        .dump          (dif.master),
        .halted_o      (halted),
        .timeout_o     (timeout),
        .done_o        (done),
        .cycle_cnt_o   (cnt),
        .checksum_o    (checksum)
    );

    always #5 clk = ~clk;

    assign reg_data = regs[reg_addr];
    assign mem_data = mems[mem_addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: a word is consumed on the coming edge when valid & ready.
    always @(negedge clk) begin
        if (!rst && dif.dump_valid_o && dif.dump_ready_i) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_word: got mem=%0d idx=%0d want no word",
                         dif.dump_is_mem_o, dif.dump_idx_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("dump_data",   64'(dif.dump_data_o),   64'(e.d));
                chk("dump_is_mem", 64'(dif.dump_is_mem_o), 64'(e.m));
                chk("dump_idx",    64'(dif.dump_idx_o),    64'(e.i));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.d = regs[i]; e.m = 1'b0; e.i = 5'(i);
            q.push_back(e);
        end
        for (int j = 0; j < 32; j++) begin
            e.d = mems[j]; e.m = 1'b1; e.i = 5'(j);
            q.push_back(e);
        end
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 8; i++) regs[i] = 32'h100 + 32'(i);
        regs[3] = 32'h1234;
        for (int j = 0; j < 32; j++) mems[j] = 32'hA000 + 32'(j);
    endtask

    task automatic do_reset();
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; dif.dump_ready_i = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!dif.dump_valid_o && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!dif.dump_valid_o) chk({nm, "_valid_wait"}, 64'(dif.dump_valid_o), 64'd1);
    endtask

    // Accept words until done; optionally hold ready low two cycles on r3.
    task automatic consume(input bit stall3, output int ncyc);
        int stl = 0;
        ncyc = 0;
        while (!done && ncyc < 200) begin
            if (stall3 && dif.dump_valid_o && !dif.dump_is_mem_o &&
                dif.dump_idx_o == 5'd3 && stl < 2) begin
                dif.dump_ready_i = 1'b0;
                stl++;
                @(negedge clk);
                chk("stall_data", 64'(dif.dump_data_o), 64'h1234);
                chk("stall_idx",  64'(dif.dump_idx_o),  64'd3);
            end else begin
                dif.dump_ready_i = 1'b1;
            end
            @(posedge clk); #1; ncyc++;
        end
        dif.dump_ready_i = 1'b0;
    endtask

    initial begin
        int lat, n, ncyc;

        // Halt on the 5th instruction
        fill_pattern();
        do_reset();
        chk("rst_stall",    64'(cpu_stall),        64'd0);
        chk("rst_valid",    64'(dif.dump_valid_o), 64'd0);
        chk("rst_halted",   64'(halted),           64'd0);
        chk("rst_timeout",  64'(timeout),          64'd0);
        chk("rst_done",     64'(done),             64'd0);
        chk("rst_cnt",      64'(cnt),              64'd0);
        chk("rst_checksum", 64'(checksum),         64'd0);
        push_expected();
        for (int k = 0; k < 4; k++) begin
            instr = 16'h0001 + 16'(k); instr_valid = 1'b1;
            @(posedge clk); #1;
        end
        instr = 16'hFFFF;
        @(posedge clk); #1;
        lat = 1;
        instr = 16'h0002;  // keeps executing during drain; must not count
        chk("t1_halted",  64'(halted),           64'd1);
        chk("t1_timeout", 64'(timeout),          64'd0);
        chk("t1_cnt",     64'(cnt),              64'd4);
        chk("t1_stall_drain", 64'(cpu_stall),    64'd0);
        while (!dif.dump_valid_o && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        instr_valid = 1'b0;
        chk("t1_first_valid_latency", 64'(lat), 64'd3);
        chk("t1_cnt_frozen", 64'(cnt),          64'd4);
        chk("t1_stall_dump", 64'(cpu_stall),    64'd1);
        consume(1'b0, ncyc);
        chk("t1_dump_cycles", 64'(ncyc),        64'd40);
        chk("t1_done",        64'(done),        64'd1);
        chk("t1_valid_done",  64'(dif.dump_valid_o), 64'd0);
        chk("t1_stall_done",  64'(cpu_stall),   64'd1);
        chk("t1_all_words",   64'(q.size()),    64'd0);

        // Timeout at MAX_CYCLES, with ready stalls on r3
        do_reset();
        push_expected();
        n = 0;
        instr = 16'h0042; instr_valid = 1'b1;
        while (!timeout && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("t2_timeout_at", 64'(n),       64'd200);
        chk("t2_cnt",        64'(cnt),     64'd200);
        chk("t2_halted",     64'(halted),  64'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("t2_cnt_sat",    64'(cnt),     64'd200);
        chk("t2_valid_up",   64'(dif.dump_valid_o), 64'd1);
        instr_valid = 1'b0;
        consume(1'b1, ncyc);
        chk("t2_dump_cycles", 64'(ncyc),     64'd42);
        chk("t2_done",        64'(done),     64'd1);
        chk("t2_all_words",   64'(q.size()), 64'd0);

        // Halt on the 200th instruction, then reset during mem word 10
        do_reset();
        push_expected();
        instr = 16'h0007; instr_valid = 1'b1;
        repeat (199) begin
            @(posedge clk); #1;
        end
        instr = 16'hFFFF;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("t3_halted",  64'(halted),  64'd1);
        chk("t3_timeout", 64'(timeout), 64'd0);
        chk("t3_cnt",     64'(cnt),     64'd199);
        wait_valid("t3");
        dif.dump_ready_i = 1'b1;
        n = 0;
        while (!(dif.dump_is_mem_o && dif.dump_idx_o == 5'd10) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("t3_reached_mem10", 64'(n), 64'd18);
        rst = 1'b1;
        @(posedge clk); #1;
        q.delete();
        chk("t3_rst_stall",  64'(cpu_stall),        64'd0);
        chk("t3_rst_valid",  64'(dif.dump_valid_o), 64'd0);
        chk("t3_rst_cnt",    64'(cnt),              64'd0);
        chk("t3_rst_halted", 64'(halted),           64'd0);
        chk("t3_rst_done",   64'(done),             64'd0);
        chk("t3_rst_state",  64'(dut.state),        64'(RUN));
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("t3_no_more_valid", 64'(dif.dump_valid_o), 64'd0);
        dif.dump_ready_i = 1'b0;

        // Checksum: regs all 1, mem all 2, halt immediately
        for (int i = 0; i < 8; i++) regs[i] = 32'd1;
        for (int j = 0; j < 32; j++) mems[j] = 32'd2;
        do_reset();
        push_expected();
        instr = 16'hFFFF; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("t4_halted", 64'(halted), 64'd1);
        chk("t4_cnt",    64'(cnt),    64'd0);
        wait_valid("t4");
        consume(1'b0, ncyc);
        chk("t4_done", 64'(done), 64'd1);
`ifdef MON_CHECKSUM_EN
        chk("t4_checksum", 64'(checksum), 64'd72);
`else
        chk("t4_checksum", 64'(checksum), 64'd0);
`endif
        chk("t4_all_words", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesizable run monitor that sits beside the single-cycle CPU, replacing the fixed-count, halt-watching logic of the simulation bench with a parametrised hardware block. It counts executed instructions and ends the run on the halt word or a cycle limit. It then stalls the CPU and streams the register file and data memory out over a valid/ready port, with an optional running checksum.

## Interface

Parameters:
- INSTR_W, 16: instruction width.
- HALT_WORD, all ones of INSTR_W: run-terminating instruction encoding.
- MAX_CYCLES, 200: timeout limit in executed instructions; must be at least 1.
- DRAIN_CYCLES, 2: cycles the CPU keeps running after the end condition; 0 allowed.
- NREG, 8: register-file entries dumped.
- NMEM, 32: data-memory words dumped.
- DATA_W, 32: register/memory word width.
- CNT_W, 16: cycle-counter width; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active-high (1 = reset), sampled on clk_i.
- instr_i  in  INSTR_W  instruction currently fetched by the CPU.
- instr_valid_i  in  1  CPU executes instr_i this cycle.
- cpu_stall_o  out  1  freezes the CPU PC and all writes.
- reg_addr_o  out  clog2(NREG)  register-file read address.
- reg_data_i  in  DATA_W  combinational read data for reg_addr_o.
- mem_addr_o  out  clog2(NMEM)  data-memory word read address.
- mem_data_i  in  DATA_W  combinational read data for mem_addr_o.
- dump_valid_o  out  1  dump word available.
- dump_ready_i  in  1  consumer accepts the word.
- dump_data_o  out  DATA_W  dump word.
- dump_is_mem_o  out  1  0 = register section, 1 = memory section.
- dump_idx_o  out  max(clog2(NREG), clog2(NMEM))  index within the section.
- halted_o  out  1  run ended on HALT_WORD.
- timeout_o  out  1  run ended on MAX_CYCLES.
- done_o  out  1  dump complete.
- cycle_cnt_o  out  CNT_W  executed-instruction count.
- checksum_o  out  DATA_W  dump checksum (see Configuration).

## Operation

- The FSM has five states: RUN, DRAIN, DUMP_REG, DUMP_MEM, DONE.
- RUN:
  - cycle_cnt increments on each instr_valid_i.
  - If instr_valid_i and instr_i == HALT_WORD: set halted_o and go to DRAIN. The halt instruction is not counted.
  - Otherwise, if instr_valid_i and the count reaches MAX_CYCLES after increment: set timeout_o and go to DRAIN.
  - If both conditions hold in the same cycle, halt wins and timeout_o stays 0.
- DRAIN:
  - Waits exactly DRAIN_CYCLES cycles. cpu_stall_o stays 0 and the counter is frozen.
  - Then goes to DUMP_REG. With DRAIN_CYCLES = 0, DUMP_REG is entered on the cycle after the end condition.
- DUMP_REG and DUMP_MEM:
  - cpu_stall_o = 1 and dump_valid_o = 1.
  - The index register drives reg_addr_o/mem_addr_o and dump_idx_o. dump_data_o is reg_data_i or mem_data_i, selected by section.
  - The index advances only on dump_valid_o & dump_ready_i. Data stays stable while the consumer stalls, because the CPU is frozen.
  - After index NREG-1 is accepted: clear the index and go to DUMP_MEM.
  - After index NMEM-1 is accepted: go to DONE.
- DONE:
  - done_o = 1, cpu_stall_o = 1, dump_valid_o = 0.
  - Holds until reset.
- Arithmetic:
  - Counter and index are unsigned.
  - cycle_cnt never wraps: it saturates at MAX_CYCLES.

## Timing

- Reset values:
  - state RUN; all outputs 0; cycle_cnt_o 0; checksum_o 0; index 0.
- Latency:
  - halted_o/timeout_o rise one cycle after the triggering edge.
  - The first dump_valid_o appears DRAIN_CYCLES+1 cycles after that edge.
- Throughput: one word per cycle with dump_ready_i held high. The full dump takes NREG+NMEM cycles.
- Reset mid-dump: the next cycle is RUN with outputs cleared and stall released. The partial dump is abandoned; no further valid is issued.
- dump_ready_i is ignored outside the DUMP states.
- instr_valid_i is ignored outside RUN.

## Configuration

- MON_CHECKSUM_EN defined:
  - checksum_o = mod-2^DATA_W sum of every accepted dump word, updated on the same edge as the index advance.
  - The final value is valid when done_o rises.
- Not defined: checksum_o is tied to 0 and no accumulator register is generated.

## Structure

- Package cpu_mon_pkg holds:
  - the state enum (RUN, DRAIN, DUMP_REG, DUMP_MEM, DONE);
  - section encodings SEC_REG=0, SEC_MEM=1;
  - the default HALT_WORD constant.
- Sub-module mon_dump_seq is the valid/ready index sequencer across both sections. It is instantiated once; the top keeps the run/drain FSM and the counter.

## Test plan

- Halt word at the 5th instruction, DRAIN_CYCLES=2, ready held at 1 -> cycle_cnt_o=4, halted_o=1, timeout_o=0. First valid appears 3 cycles after the halt edge. 40 words are delivered: regs 0..7, then mem 0..31. done_o rises after the last word.
- No halt, MAX_CYCLES=200 -> timeout_o=1 with cycle_cnt_o=200. cycle_cnt_o does not increment after that.
- Halt word on the 200th valid instruction -> halted_o=1, timeout_o=0, cycle_cnt_o=199.
- Ready toggled 1,0,0,1 with reg r3=0x1234 -> dump_data_o stays 0x1234 with dump_idx_o=3 through both stall cycles. Each word is delivered exactly once.
- Reset asserted during memory word 10 -> the next cycle shows cpu_stall_o=0, dump_valid_o=0, cycle_cnt_o=0, state RUN.
- MON_CHECKSUM_EN set, regs all 1, mem all 2 -> checksum_o=72 at done_o. Without the macro -> checksum_o=0.
